// File: rtl/spi_target.sv
// SPI mode-0 target: synchronizes the SPI pins into clk, shifts bytes MSB first,
// with a one-byte TX buffer and a single-entry RX holding register with overrun flag.
module spi_target #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_load,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun
);

   typedef enum logic {StIdle, StActive} state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
   logic                   sclk_prev_q, csn_prev_q;
   logic                   sclk_s, mosi_s, csn_s;
   logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] tx_buf_q, tx_buf_d;
   logic       tx_full_q, tx_full_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       rx_ovr_q, rx_ovr_d;
   logic       tx_reload, byte_done;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign csn_s  = csn_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign cs_fall   = ~csn_s & csn_prev_q;
   assign cs_rise   = csn_s & ~csn_prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         csn_sync_q  <= '1;
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         sclk_prev_q <= sclk_s;
         csn_prev_q  <= csn_s;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      tx_reload  = 1'b0;
      byte_done  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cs_fall) begin
               state_d   = StActive;
               bit_cnt_d = '0;
               tx_reload = 1'b1;
            end
         end
         StActive: begin
            if (cs_rise) begin
               // Partial RX bits and the in-flight TX byte are simply abandoned.
               state_d   = StIdle;
               bit_cnt_d = '0;
            end else if (sclk_rise) begin
               rx_shift_d = {rx_shift_q[5:0], mosi_s};
               bit_cnt_d  = bit_cnt_q + 3'd1;
               byte_done  = (bit_cnt_q == 3'd7);
            end else if (sclk_fall) begin
               if (bit_cnt_q == 3'd0) begin
                  tx_reload = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (tx_reload) begin
         tx_shift_d = tx_full_q ? tx_buf_q : 8'hFF;
      end
   end

   // A load arriving while the shifter reloads from an empty buffer lands in the buffer.
   always_comb begin
      tx_full_d = tx_full_q;
      tx_buf_d  = tx_buf_q;
      if (tx_reload && tx_full_q) begin
         tx_full_d = 1'b0;
      end else if (tx_load && !tx_full_q) begin
         tx_full_d = 1'b1;
         tx_buf_d  = tx_data;
      end
   end

   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      if (byte_done) begin
         rx_data_d  = {rx_shift_q, mosi_s};
         rx_valid_d = 1'b1;
         rx_ovr_d   = rx_ack ? 1'b0 : (rx_ovr_q | rx_valid_q);
      end else if (rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         rx_ovr_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         tx_buf_q   <= '0;
         tx_full_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         tx_buf_q   <= tx_buf_d;
         tx_full_q  <= tx_full_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign spi_miso   = (state_q == StActive) ? tx_shift_q[7] : 1'b1;
   assign tx_ready   = ~tx_full_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios plus random frames, checked
// against a byte-level model of the TX buffer and RX holding register.
module tb_spi_target;

   localparam int P = 6;  // SPI half-period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       spi_clk = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_miso;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack = 1'b0;
   logic       rx_overrun;

   int n_checks = 0;
   int n_fail = 0;

   bit         m_full;
   logic [7:0] m_buf;
   logic [7:0] m_rx_data;
   bit         m_valid;
   bit         m_ovr;
   logic [7:0] exp_tx;

   always #5 clk = ~clk;

   spi_target #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_clk    (spi_clk),
      .spi_mosi   (spi_mosi),
      .spi_cs_n   (spi_cs_n),
      .spi_miso   (spi_miso),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_reset();
      m_full    = 1'b0;
      m_buf     = 8'h00;
      m_rx_data = 8'h00;
      m_valid   = 1'b0;
      m_ovr     = 1'b0;
      exp_tx    = 8'hFF;
   endtask

   // Next outgoing byte: buffered byte if any, else all ones.
   task automatic tx_reload();
      if (m_full) begin
         exp_tx = m_buf;
         m_full = 1'b0;
      end else begin
         exp_tx = 8'hFF;
      end
   endtask

   task automatic do_load(input logic [7:0] v);
      tx_data = v;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
      if (!m_full) begin
         m_full = 1'b1;
         m_buf  = v;
      end
      check("tx_ready_load", tx_ready, !m_full);
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      wait_clk(1);
      rx_ack = 1'b0;
      if (m_valid) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      check("rx_valid_ack", rx_valid, m_valid);
      check("rx_overrun_ack", rx_overrun, m_ovr);
   endtask

   task automatic cs_start();
      spi_cs_n = 1'b0;
      tx_reload();
   endtask

   // tx_load lands on the same clk edge as the select-time shifter reload.
   task automatic cs_start_load(input logic [7:0] v);
      bit pre_full;
      pre_full = m_full;
      spi_cs_n = 1'b0;
      wait_clk(2);
      tx_data = v;
      tx_load = 1'b1;
      wait_clk(1);
      tx_load = 1'b0;
      tx_reload();
      if (!pre_full) begin
         m_full = 1'b1;
         m_buf  = v;
      end
      check("tx_ready_coinc", tx_ready, !m_full);
   endtask

   task automatic cs_end();
      spi_cs_n = 1'b1;
      wait_clk(P);
      check("miso_idle", spi_miso, 1'b1);
      check("tx_ready_idle", tx_ready, !m_full);
      check("rx_valid_idle", rx_valid, m_valid);
   endtask

   task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit ack_done);
      logic [7:0] mi;
      logic [7:0] want;
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = mo[7-i];
         wait_clk(P);
         mi = {mi[6:0], spi_miso};
         spi_clk = 1'b1;
         if (i == 7) begin
            wait_clk(2);
            check("rx_valid_early", rx_valid, m_valid);
            rx_ack = ack_done;
            wait_clk(1);
            rx_ack = 1'b0;
            m_ovr = ack_done ? 1'b0 : (m_ovr | m_valid);
            m_valid = 1'b1;
            m_rx_data = mo;
            check("rx_data", rx_data, m_rx_data);
            check("rx_valid", rx_valid, m_valid);
            check("rx_overrun", rx_overrun, m_ovr);
            wait_clk(P - 3);
         end else begin
            wait_clk(P);
         end
         spi_clk = 1'b0;
      end
      wait_clk(4);
      want = exp_tx >> (8 - nbits);
      check("miso_byte", mi, want);
      if (nbits == 8) tx_reload();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      int nbits;
      m_reset();
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_rx_overrun", rx_overrun, 1'b0);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_miso", spi_miso, 1'b1);

      // Buffered A5 out while 3C comes in
      do_load(8'hA5);
      cs_start();
      spi_byte(8'h3C, 8, 1'b0);
      cs_end();
      do_ack();

      // Empty buffer: all-ones out, two acked bytes
      cs_start();
      spi_byte(8'h01, 8, 1'b0);
      do_ack();
      spi_byte(8'h80, 8, 1'b0);
      do_ack();
      cs_end();

      // Overrun then single ack clears both flags
      cs_start();
      spi_byte(8'h11, 8, 1'b0);
      spi_byte(8'h22, 8, 1'b0);
      cs_end();
      do_ack();

      // Deselect mid-byte discards partial byte
      cs_start();
      spi_byte(8'hF0, 5, 1'b0);
      cs_end();
      cs_start();
      spi_byte(8'h5A, 8, 1'b0);
      cs_end();
      do_ack();

      // Ack coinciding with completion: new byte wins
      cs_start();
      spi_byte(8'h55, 8, 1'b0);
      spi_byte(8'h77, 8, 1'b1);
      cs_end();
      do_ack();

      // Buffer load coinciding with select-time reload
      cs_start_load(8'hC3);
      spi_byte(8'h96, 8, 1'b0);
      spi_byte(8'h69, 8, 1'b0);
      cs_end();
      do_ack();

      // Reset mid-byte with live state everywhere
      cs_start();
      spi_byte(8'hAB, 8, 1'b0);
      spi_byte(8'hCD, 8, 1'b0);
      do_load(8'hEE);
      spi_byte(8'h3A, 3, 1'b0);
      rst_n = 1'b0;
      spi_cs_n = 1'b1;
      wait_clk(1);
      check("mid_rst_tx_ready", tx_ready, 1'b1);
      check("mid_rst_rx_valid", rx_valid, 1'b0);
      check("mid_rst_rx_overrun", rx_overrun, 1'b0);
      check("mid_rst_rx_data", rx_data, 8'h00);
      check("mid_rst_miso", spi_miso, 1'b1);
      rst_n = 1'b1;
      m_reset();
      wait_clk(4);

      // Load while full is ignored
      do_load(8'h12);
      do_load(8'h34);
      cs_start();
      spi_byte(8'h00, 8, 1'b0);
      cs_end();
      do_ack();

      for (int f = 0; f < 25; f++) begin
         if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
         if ($urandom_range(2, 0) == 0) cs_start_load(8'($urandom));
         else cs_start();
         nb = $urandom_range(3, 1);
         for (int b = 0; b < nb; b++) begin
            nbits = 8;
            if (b == nb - 1 && $urandom_range(3, 0) == 0) nbits = $urandom_range(7, 1);
            spi_byte(8'($urandom), nbits, 1'b0);
            if (b != nb - 1) begin
               if ($urandom_range(1, 0) == 1) do_ack();
               if ($urandom_range(1, 0) == 1) do_load(8'($urandom));
            end
         end
         cs_end();
         if ($urandom_range(1, 0) == 1) do_ack();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
